// File: rtl/otter_pkg.sv
// Shared types and encodings for the OTTER multi-cycle control unit.
package otter_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_t;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_OR    = 4'b0010,
    ALU_AND   = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_SLL   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_SLT   = 4'b1000,
    ALU_SLTU  = 4'b1001,
    ALU_COPYA = 4'b1010
  } alu_fun_t;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WB    = 2'd2,
    ST_INTR  = 2'd3
  } state_t;

  localparam logic [2:0] PC_SRC_NEXT   = 3'd0;
  localparam logic [2:0] PC_SRC_JALR   = 3'd1;
  localparam logic [2:0] PC_SRC_BRANCH = 3'd2;
  localparam logic [2:0] PC_SRC_JAL    = 3'd3;
  localparam logic [2:0] PC_SRC_INTR   = 3'd4;

  localparam logic [1:0] RF_SEL_PC4 = 2'd0;
  localparam logic [1:0] RF_SEL_MEM = 2'd2;
  localparam logic [1:0] RF_SEL_ALU = 2'd3;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IIMM = 2'd1;
  localparam logic [1:0] SRCB_SIMM = 2'd2;
  localparam logic [1:0] SRCB_PC   = 2'd3;

  // Register and immediate ALU ops share the funct3 map; only the register
  // form may select sub, while both honour ir[30] for arithmetic shift.
  function automatic alu_fun_t alu_from_funct3(input logic [2:0] f3,
                                               input logic alt,
                                               input logic is_reg);
    alu_fun_t res;
    case (f3)
      3'b000:  res = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'b001:  res = ALU_SLL;
      3'b010:  res = ALU_SLT;
      3'b011:  res = ALU_SLTU;
      3'b100:  res = ALU_XOR;
      3'b101:  res = alt ? ALU_SRA : ALU_SRL;
      3'b110:  res = ALU_OR;
      default: res = ALU_AND;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/otter_cu_dcdr.sv
// Combinational instruction decoder: ir plus branch flags to ALU op,
// operand selects, PC source, write-back select and instruction class.
module otter_cu_dcdr
  import otter_pkg::*;
(
  input  logic [31:0] ir,
  input  logic        br_eq,
  input  logic        br_lt,
  input  logic        br_ltu,
  output logic [3:0]  alu_fun,
  output logic        alu_srcA,
  output logic [1:0]  alu_srcB,
  output logic [2:0]  pc_source,
  output logic [1:0]  rf_wr_sel,
  output logic        illegal,
  output logic        is_load,
  output logic        is_store,
  output logic        wr_reg
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;
  logic       br_taken;
  logic       unused_ir;

  assign opcode    = ir[6:0];
  assign funct3    = ir[14:12];
  assign alt       = ir[30];
  assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};

  // Branch condition selected by funct3; undefined encodings never branch.
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = br_eq;
      3'b001:  br_taken = !br_eq;
      3'b100:  br_taken = br_lt;
      3'b101:  br_taken = !br_lt;
      3'b110:  br_taken = br_ltu;
      3'b111:  br_taken = !br_ltu;
      default: br_taken = 1'b0;
    endcase
  end

  // Opcode decode into datapath selects and instruction class flags.
  always_comb begin
    alu_fun   = ALU_ADD;
    alu_srcA  = 1'b0;
    alu_srcB  = SRCB_RS2;
    pc_source = PC_SRC_NEXT;
    rf_wr_sel = RF_SEL_PC4;
    illegal   = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    wr_reg    = 1'b0;
    case (opcode)
      OPC_OP: begin
        alu_fun   = alu_from_funct3(funct3, alt, 1'b1);
        rf_wr_sel = RF_SEL_ALU;
        wr_reg    = 1'b1;
      end
      OPC_OP_IMM: begin
        alu_fun   = alu_from_funct3(funct3, alt, 1'b0);
        alu_srcB  = SRCB_IIMM;
        rf_wr_sel = RF_SEL_ALU;
        wr_reg    = 1'b1;
      end
      OPC_LUI: begin
        alu_fun   = ALU_COPYA;
        alu_srcA  = 1'b1;
        rf_wr_sel = RF_SEL_ALU;
        wr_reg    = 1'b1;
      end
      OPC_AUIPC: begin
        alu_srcA  = 1'b1;
        alu_srcB  = SRCB_PC;
        rf_wr_sel = RF_SEL_ALU;
        wr_reg    = 1'b1;
      end
      OPC_LOAD: begin
        alu_srcB  = SRCB_IIMM;
        rf_wr_sel = RF_SEL_MEM;
        is_load   = 1'b1;
      end
      OPC_STORE: begin
        alu_srcB  = SRCB_SIMM;
        is_store  = 1'b1;
      end
      OPC_BRANCH: begin
        pc_source = br_taken ? PC_SRC_BRANCH : PC_SRC_NEXT;
      end
      OPC_JAL: begin
        pc_source = PC_SRC_JAL;
        wr_reg    = 1'b1;
      end
      OPC_JALR: begin
        pc_source = PC_SRC_JALR;
        wr_reg    = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/otter_cu_fsm.sv
// OTTER multi-cycle control unit: FETCH/EXEC/WB/INTR sequencing and
// strobe gating around the instruction decoder.
module otter_cu_fsm
  import otter_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0
)
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] ir,
  input  logic        br_eq,
  input  logic        br_lt,
  input  logic        br_ltu,
  input  logic        intr,
  output logic        pc_write,
  output logic        reg_write,
  output logic        mem_rden1,
  output logic        mem_rden2,
  output logic        mem_we2,
  output logic [3:0]  alu_fun,
  output logic        alu_srcA,
  output logic [1:0]  alu_srcB,
  output logic [2:0]  pc_source,
  output logic [1:0]  rf_wr_sel,
  output logic        int_taken,
  output logic        illegal
);

  state_t     state_q, state_d;
  logic [3:0] dec_alu_fun;
  logic       dec_srcA;
  logic [1:0] dec_srcB;
  logic [2:0] dec_pc_source;
  logic [1:0] dec_rf_wr_sel;
  logic       dec_illegal;
  logic       dec_is_load;
  logic       dec_is_store;
  logic       dec_wr_reg;
  logic       unused_reset_vec;

  // The reset vector belongs to the PC, not to this block.
  assign unused_reset_vec = ^RESET_VEC;

  otter_cu_dcdr u_dcdr (
    .ir        (ir),
    .br_eq     (br_eq),
    .br_lt     (br_lt),
    .br_ltu    (br_ltu),
    .alu_fun   (dec_alu_fun),
    .alu_srcA  (dec_srcA),
    .alu_srcB  (dec_srcB),
    .pc_source (dec_pc_source),
    .rf_wr_sel (dec_rf_wr_sel),
    .illegal   (dec_illegal),
    .is_load   (dec_is_load),
    .is_store  (dec_is_store),
    .wr_reg    (dec_wr_reg)
  );

  // State register with synchronous reset to FETCH.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  // Next state: intr is only looked at in the last cycle of an instruction.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC:  state_d = dec_is_load ? ST_WB : (intr ? ST_INTR : ST_FETCH);
      ST_WB:    state_d = intr ? ST_INTR : ST_FETCH;
      ST_INTR:  state_d = ST_FETCH;
      default:  state_d = ST_FETCH;
    endcase
  end

  // Outputs: everything low in reset and FETCH selects idle; decode drives
  // the selects in EXEC/WB, INTR forces the interrupt vector.
  always_comb begin
    pc_write  = 1'b0;
    reg_write = 1'b0;
    mem_rden1 = 1'b0;
    mem_rden2 = 1'b0;
    mem_we2   = 1'b0;
    alu_fun   = ALU_ADD;
    alu_srcA  = 1'b0;
    alu_srcB  = SRCB_RS2;
    pc_source = PC_SRC_NEXT;
    rf_wr_sel = RF_SEL_PC4;
    int_taken = 1'b0;
    illegal   = 1'b0;
    if (!RST) begin
      case (state_q)
        ST_FETCH: begin
          mem_rden1 = 1'b1;
        end
        ST_EXEC: begin
          alu_fun   = dec_alu_fun;
          alu_srcA  = dec_srcA;
          alu_srcB  = dec_srcB;
          pc_source = dec_pc_source;
          rf_wr_sel = dec_rf_wr_sel;
          illegal   = dec_illegal;
          mem_rden2 = dec_is_load;
          pc_write  = !dec_is_load;
          reg_write = dec_wr_reg;
          mem_we2   = dec_is_store;
        end
        ST_WB: begin
          alu_fun   = dec_alu_fun;
          alu_srcA  = dec_srcA;
          alu_srcB  = dec_srcB;
          pc_source = dec_pc_source;
          rf_wr_sel = RF_SEL_MEM;
          reg_write = 1'b1;
          pc_write  = 1'b1;
        end
        ST_INTR: begin
          int_taken = 1'b1;
          pc_write  = 1'b1;
          pc_source = PC_SRC_INTR;
        end
        default: begin
          pc_write = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Testbench for otter_cu_fsm: directed scenarios plus randomized
// instruction streams against a cycle-list reference model.
module tb_otter_cu_fsm;

  logic        CLK;
  logic        RST;
  logic [31:0] ir;
  logic        br_eq, br_lt, br_ltu;
  logic        intr;
  logic        pc_write, reg_write, mem_rden1, mem_rden2, mem_we2;
  logic [3:0]  alu_fun;
  logic        alu_srcA;
  logic [1:0]  alu_srcB;
  logic [2:0]  pc_source;
  logic [1:0]  rf_wr_sel;
  logic        int_taken, illegal;

  int passed = 0;
  int total  = 0;

  // {pc_write, reg_write, mem_rden1, mem_rden2, mem_we2, alu_fun, srcA,
  //  srcB, pc_source, rf_wr_sel, int_taken, illegal}
  logic [18:0] obs;
  logic [18:0] exp_q[$];
  localparam logic [18:0] FETCH_V = 19'b0010_0000_0000_00000_00;
  localparam logic [3:0]  F3_ALU [8] = '{4'd0, 4'd6, 4'd8, 4'd9, 4'd4, 4'd5, 4'd2, 4'd3};

  assign obs = {pc_write, reg_write, mem_rden1, mem_rden2, mem_we2, alu_fun,
                alu_srcA, alu_srcB, pc_source, rf_wr_sel, int_taken, illegal};

  otter_cu_fsm #(.RESET_VEC(32'h0)) dut (
    .CLK(CLK), .RST(RST), .ir(ir), .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu),
    .intr(intr), .pc_write(pc_write), .reg_write(reg_write), .mem_rden1(mem_rden1),
    .mem_rden2(mem_rden2), .mem_we2(mem_we2), .alu_fun(alu_fun), .alu_srcA(alu_srcA),
    .alu_srcB(alu_srcB), .pc_source(pc_source), .rf_wr_sel(rf_wr_sel),
    .int_taken(int_taken), .illegal(illegal)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: list the cycles one instruction occupies, built from the
  // instruction's meaning (operand compare for branches) rather than states.
  function automatic void model_instr(input logic [31:0] r, input logic [31:0] a,
                                      input logic [31:0] b, input logic irq);
    logic [6:0] op;
    logic [2:0] f3;
    logic [3:0] fun;
    logic       sa, wr, ld, st, ill, taken;
    logic [1:0] sb, rf;
    logic [2:0] ps;
    op = r[6:0]; f3 = r[14:12];
    fun = 4'd0; sa = 0; sb = 0; ps = 0; rf = 0; wr = 0; ld = 0; st = 0; ill = 0;
    case (f3)
      3'd0: taken = (a == b);
      3'd1: taken = (a != b);
      3'd4: taken = ($signed(a) <  $signed(b));
      3'd5: taken = ($signed(a) >= $signed(b));
      3'd6: taken = (a <  b);
      3'd7: taken = (a >= b);
      default: taken = 1'b0;
    endcase
    case (op)
      7'h33: begin
        fun = F3_ALU[f3];
        if (r[30] && f3 == 3'd0) fun = 4'd1;
        if (r[30] && f3 == 3'd5) fun = 4'd7;
        rf = 2'd3; wr = 1;
      end
      7'h13: begin
        fun = F3_ALU[f3];
        if (r[30] && f3 == 3'd5) fun = 4'd7;
        sb = 2'd1; rf = 2'd3; wr = 1;
      end
      7'h37: begin fun = 4'd10; sa = 1; rf = 2'd3; wr = 1; end
      7'h17: begin sa = 1; sb = 2'd3; rf = 2'd3; wr = 1; end
      7'h03: begin sb = 2'd1; rf = 2'd2; ld = 1; end
      7'h23: begin sb = 2'd2; st = 1; end
      7'h63: ps = taken ? 3'd2 : 3'd0;
      7'h6f: begin ps = 3'd3; wr = 1; end
      7'h67: begin ps = 3'd1; wr = 1; end
      default: ill = 1;
    endcase
    exp_q.push_back(FETCH_V);
    if (ld) begin
      exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b1, 1'b0, fun, sa, sb, ps, rf, 1'b0, 1'b0});
      exp_q.push_back({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, fun, sa, sb, ps, 2'd2, 1'b0, 1'b0});
    end else begin
      exp_q.push_back({1'b1, wr, 1'b0, 1'b0, st, fun, sa, sb, ps, rf, 1'b0, ill});
    end
    if (irq) exp_q.push_back({1'b1, 4'b0, 4'd0, 1'b0, 2'd0, 3'd4, 2'd0, 1'b1, 1'b0});
  endfunction

  task automatic test_reset();
    RST = 1'b1; ir = 32'h002081B3; br_eq = 0; br_lt = 0; br_ltu = 0; intr = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      total++;
      if (obs !== 19'd0) $display("FAIL reset_outputs[%0d]: got %h want %h", i, obs, 19'd0);
      else passed++;
      tick();
    end
    RST = 1'b0;
    @(negedge CLK);
    total++;
    if (obs !== FETCH_V) $display("FAIL reset_first_fetch: got %h want %h", obs, FETCH_V);
    else passed++;
    tick();
    @(negedge CLK);
    total++;
    if ({alu_fun, reg_write, pc_write} !== {4'd0, 1'b1, 1'b1})
      $display("FAIL reset_first_exec: got %h want %h", {alu_fun, reg_write, pc_write}, 6'b000011);
    else passed++;
    tick();
  endtask

  task automatic test_sub();
    ir = 32'h402081B3;
    @(negedge CLK);
    tick();
    @(negedge CLK);
    total++;
    if ({alu_fun, alu_srcB, rf_wr_sel} !== {4'd1, 2'd0, 2'd3})
      $display("FAIL sub_exec: got %h want %h", {alu_fun, alu_srcB, rf_wr_sel}, {4'd1, 2'd0, 2'd3});
    else passed++;
    tick();
  endtask

  task automatic test_load();
    ir = 32'h0040A283;
    @(negedge CLK);
    total++;
    if (obs !== FETCH_V) $display("FAIL load_fetch: got %h want %h", obs, FETCH_V);
    else passed++;
    tick();
    @(negedge CLK);
    total++;
    if ({mem_rden2, pc_write, reg_write} !== 3'b100)
      $display("FAIL load_exec: got %b want %b", {mem_rden2, pc_write, reg_write}, 3'b100);
    else passed++;
    tick();
    @(negedge CLK);
    total++;
    if ({reg_write, rf_wr_sel, pc_write, mem_rden2} !== {1'b1, 2'd2, 1'b1, 1'b0})
      $display("FAIL load_wb: got %b want %b", {reg_write, rf_wr_sel, pc_write, mem_rden2}, 5'b11010);
    else passed++;
    tick();
  endtask

  task automatic test_branch();
    ir = 32'h00208463;
    for (int t = 1; t >= 0; t--) begin
      br_eq = t[0];
      @(negedge CLK);
      tick();
      @(negedge CLK);
      total++;
      if ({pc_source, reg_write, pc_write} !== {(t == 1) ? 3'd2 : 3'd0, 1'b0, 1'b1})
        $display("FAIL beq_eq%0d: got %b want %b", t, {pc_source, reg_write, pc_write},
                 {(t == 1) ? 3'd2 : 3'd0, 1'b0, 1'b1});
      else passed++;
      tick();
    end
    br_eq = 1'b0;
  endtask

  task automatic test_intr();
    ir = 32'h002081B3; intr = 1'b1;
    @(negedge CLK);
    total++;
    if ({mem_rden1, int_taken, pc_write} !== 3'b100)
      $display("FAIL intr_fetch_deferred: got %b want %b", {mem_rden1, int_taken, pc_write}, 3'b100);
    else passed++;
    tick();
    @(negedge CLK);
    total++;
    if ({reg_write, pc_write, int_taken} !== 3'b110)
      $display("FAIL intr_exec_completes: got %b want %b", {reg_write, pc_write, int_taken}, 3'b110);
    else passed++;
    tick();
    @(negedge CLK);
    total++;
    if ({int_taken, pc_source, pc_write, reg_write} !== {1'b1, 3'd4, 1'b1, 1'b0})
      $display("FAIL intr_taken: got %b want %b", {int_taken, pc_source, pc_write, reg_write}, 6'b110010);
    else passed++;
    tick();
    // intr still held: the next add must run fully before another INTR
    @(negedge CLK);
    total++;
    if ({mem_rden1, int_taken} !== 2'b10)
      $display("FAIL intr_then_fetch: got %b want %b", {mem_rden1, int_taken}, 2'b10);
    else passed++;
    tick();
    @(negedge CLK);
    total++;
    if ({reg_write, pc_write, int_taken} !== 3'b110)
      $display("FAIL intr_held_exec: got %b want %b", {reg_write, pc_write, int_taken}, 3'b110);
    else passed++;
    tick();
    @(negedge CLK);
    total++;
    if ({int_taken, pc_source} !== {1'b1, 3'd4})
      $display("FAIL intr_second: got %b want %b", {int_taken, pc_source}, 4'b1100);
    else passed++;
    intr = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    ir = 32'hFFFFFFFF;
    @(negedge CLK);
    tick();
    @(negedge CLK);
    total++;
    if ({illegal, reg_write, mem_we2, pc_write, pc_source} !== {4'b1001, 3'd0})
      $display("FAIL illegal_exec: got %b want %b", {illegal, reg_write, mem_we2, pc_write, pc_source}, 7'b1001000);
    else passed++;
    tick();
    @(negedge CLK);
    total++;
    if (obs !== FETCH_V) $display("FAIL illegal_back_to_fetch: got %h want %h", obs, FETCH_V);
    else passed++;
    tick();
    tick();
  endtask

  task automatic test_reset_abort();
    ir = 32'h0040A283;
    @(negedge CLK);
    tick();
    RST = 1'b1;
    @(negedge CLK);
    total++;
    if (obs !== 19'd0) $display("FAIL abort_outputs: got %h want %h", obs, 19'd0);
    else passed++;
    tick();
    RST = 1'b0; ir = 32'h002081B3;
    @(negedge CLK);
    total++;
    if (obs !== FETCH_V) $display("FAIL abort_refetch: got %h want %h", obs, FETCH_V);
    else passed++;
    tick();
    @(negedge CLK);
    tick();
  endtask

  task automatic test_random();
    logic [31:0] r, a, b;
    logic [18:0] e;
    logic        irq;
    int          idx;
    logic [6:0]  opc_tab [9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67};
    for (int n = 0; n < 200; n++) begin
      r   = $urandom;
      idx = $urandom_range(0, 9);
      if (idx < 9) r[6:0] = opc_tab[idx];
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      irq = ($urandom_range(0, 3) == 0);
      ir = r; br_eq = (a == b); br_lt = ($signed(a) < $signed(b)); br_ltu = (a < b);
      intr = irq;
      model_instr(r, a, b, irq);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        @(negedge CLK);
        total++;
        if (obs !== e) $display("FAIL random[%0d] ir=%h: got %h want %h", n, r, obs, e);
        else passed++;
        tick();
      end
    end
    intr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sub();
    test_load();
    test_branch();
    test_intr();
    test_illegal();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/otter_cu_fsm.md
# otter_cu_fsm

Multi-cycle control unit for the OTTER RV32I core and the source of every ALU operation code and operand select. It steps each instruction through FETCH, EXEC, an optional WRITEBACK for loads, and an optional INTERRUPT. It decodes the instruction register into `alu_fun`, operand-mux selects, PC source, register-file write select, and memory/register strobes. It sits between instruction memory / branch-condition logic and the datapath (ALU, register file, PC, data memory).

## Interface
- `RESET_VEC`, default 32'h0. Not used internally; documented for top-level consistency only.
- `CLK`  in  1  system clock, rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `ir`  in  32  current instruction from instruction memory, valid from EXEC onward.
- `br_eq`, `br_lt`, `br_ltu`  in  1 each  rs1/rs2 compare results (signed lt, unsigned ltu).
- `intr`  in  1  level interrupt request.
- `pc_write`  out  1  PC load strobe.
- `reg_write`  out  1  register-file write strobe.
- `mem_rden1`  out  1  instruction-memory read.
- `mem_rden2`  out  1  data-memory read.
- `mem_we2`  out  1  data-memory write.
- `alu_fun`  out  4  ALU operation.
- `alu_srcA`  out  1  0 = rs1, 1 = U-immediate.
- `alu_srcB`  out  2  0 = rs2, 1 = I-imm, 2 = S-imm, 3 = PC.
- `pc_source`  out  3  0 = PC+4, 1 = JALR, 2 = branch, 3 = JAL, 4 = interrupt vector.
- `rf_wr_sel`  out  2  0 = PC+4, 2 = memory, 3 = ALU.
- `int_taken`  out  1  one-cycle pulse when the interrupt is taken.
- `illegal`  out  1  unsupported opcode in EXEC.

## Operation
- `alu_fun` codes:
  - 0000 add, 0001 sub, 0010 or, 0011 and, 0100 xor.
  - 0101 srl, 0110 sll, 0111 sra.
  - 1000 slt, 1001 sltu, 1010 copy A.
- OP (0110011), decoded from funct3:
  - 000 → sub if `ir[30]`, else add.
  - 001 → sll; 010 → slt; 011 → sltu; 100 → xor.
  - 101 → sra if `ir[30]`, else srl.
  - 110 → or; 111 → and.
  - Selects: srcA=0, srcB=0, rf_wr_sel=3.
- OP-IMM (0010011): same mapping, except 000 is always add. srcB=1, rf_wr_sel=3.
- LUI: alu_fun=1010, srcA=1, rf_wr_sel=3.
- AUIPC: add, srcA=1, srcB=3, rf_wr_sel=3.
- LOAD: add, srcB=1, rf_wr_sel=2.
- STORE: add, srcB=2, `mem_we2` in EXEC.
- BRANCH: `pc_source`=2 if taken, else 0.
  - beq: `br_eq`; bne: `!br_eq`.
  - blt: `br_lt`; bge: `!br_lt`.
  - bltu: `br_ltu`; bgeu: `!br_ltu`.
  - Undefined funct3 → not taken.
- JAL: pc_source=3, rf_wr_sel=0. JALR: pc_source=1, rf_wr_sel=0.
- Any other opcode: `illegal`=1, no reg/mem writes, pc_source=0, `pc_write`=1.
- States: FETCH, EXEC, WB, INTR.
  - FETCH: `mem_rden1`=1 → EXEC.
  - EXEC, LOAD: `mem_rden2`=1 → WB.
  - EXEC, otherwise: `pc_write`=1; `reg_write`=1 for OP, OP-IMM, LUI, AUIPC, JAL and JALR → INTR if `intr`, else FETCH.
  - WB: `reg_write`=1, `pc_write`=1, rf_wr_sel=2 → INTR if `intr`, else FETCH.
  - INTR: `int_taken`=1, `pc_write`=1, pc_source=4 → FETCH.
- Outputs are combinational from state and `ir`. Strobes not listed for a state are 0.

## Timing
- While RST=1: state ← FETCH at the clock edge, and every output is forced to 0 (including `alu_fun`=0000 and `mem_rden1`=0).
- First cycle after RST falls: FETCH with `mem_rden1`=1.
- RST asserted in any state aborts the instruction at the next edge; no write strobe occurs in that cycle.
- Latency:
  - Non-load instructions: 2 cycles.
  - Loads: 3 cycles.
  - A taken interrupt adds 1 cycle.
- `intr` is sampled only in the final cycle of an instruction (EXEC for non-loads, WB for loads).
  - `intr` high in FETCH, or in EXEC of a load, is deferred, not lost, provided it is still held.
  - `intr` held high through INTR causes the next instruction to complete before the next INTR (INTR → FETCH always).
- `int_taken` is exactly one cycle wide.
- `pc_write` is asserted exactly once per instruction, plus once per INTR.

## Structure
- Shared package `otter_pkg`: opcode enum, `alu_fun` enum (codes above), state enum, and pc_source / rf_wr_sel / srcB encodings as named constants.
- Sub-module `otter_cu_dcdr`: combinational decode of `ir` plus branch flags into alu_fun, srcA, srcB, pc_source, rf_wr_sel and illegal.
- `otter_cu_fsm` itself holds only the state register, next-state logic and strobe gating.

## Test plan
- Reset: RST=1 for 2 cycles with `ir`=0x002081B3 → all outputs 0. After release: FETCH (`mem_rden1`=1), then EXEC with alu_fun=0000, `reg_write`=1, `pc_write`=1.
- `ir`=0x402081B3 (sub) → EXEC alu_fun=0001, srcB=0, rf_wr_sel=3. FETCH follows.
- `ir`=0x0040A283 (lw) → EXEC `mem_rden2`=1, `pc_write`=0. Next cycle WB: `reg_write`=1, rf_wr_sel=2, `pc_write`=1.
- `ir`=0x00208463 (beq):
  - `br_eq`=1 → pc_source=2.
  - `br_eq`=0 → pc_source=0.
  - `reg_write`=0 in both cases.
- `intr`=1 asserted during FETCH of an add, held → EXEC completes, then INTR: `int_taken`=1 for one cycle, pc_source=4, then FETCH.
- `ir`=0xFFFFFFFF → `illegal`=1, `reg_write`=`mem_we2`=0, `pc_write`=1, return to FETCH.
